// File: rtl/robot_pkg.sv
// Shared definitions for the robot sensor front end: power state encoding,
// default timing parameters and debounce channel indices.
package robot_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    BAT_LOW = 2'd2
  } pwr_state_e;

  localparam int unsigned DEB_CYCLES_DEF   = 16;
  localparam int unsigned STUCK_CYCLES_DEF = 50000;

  localparam int unsigned CH_F   = 0;
  localparam int unsigned CH_T   = 1;
  localparam int unsigned CH_LE  = 2;
  localparam int unsigned CH_LD  = 3;
  localparam int unsigned CH_BAT = 4;
  localparam int unsigned CH_BTN = 5;
  localparam int unsigned NUM_CH = 6;

endpackage

// File: rtl/sensor_frontend_if.sv
// Raw sensor inputs and conditioned outputs of the sensor front end.
// master: the board/environment side; slave: the front end itself.
interface sensor_frontend_if;
  logic F, T, LE, LD;
  logic bateria;
  logic botao;
  logic f_c, t_c, le_c, ld_c;
  logic bat_ok;
  logic power_on;
  logic bat_low;
  logic obst_any;
  logic sens_chg;
  logic fault;

  modport master (
    output F, T, LE, LD, bateria, botao,
    input  f_c, t_c, le_c, ld_c, bat_ok, power_on, bat_low, obst_any, sens_chg, fault
  );

  modport slave (
    input  F, T, LE, LD, bateria, botao,
    output f_c, t_c, le_c, ld_c, bat_ok, power_on, bat_low, obst_any, sens_chg, fault
  );
endinterface

// File: rtl/debounce_ch.sv
// One-bit 2-FF synchronizer followed by a stability-count debouncer.
// The clean level flips only after DEB_CYCLES consecutive cycles of disagreement.
module debounce_ch #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles where the synced input differs from the clean level
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      clean_d = ~clean_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and debounce state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = clean_q;

endmodule

// File: rtl/sensor_frontend.sv
// Sensor front end: debounces obstacle sensors, battery flag and button,
// runs the power state machine and produces change strobes and alarms.
// Optional stuck-sensor detection is built when STUCK_DETECT_EN is defined.
module sensor_frontend
  import robot_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF,
  parameter int unsigned STUCK_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  sensor_frontend_if.slave   bus
);

  logic [NUM_CH-1:0] raw, clean;
  logic [3:0]        obst_c;
  logic              bat_ok, btn_c;

  logic              btn_prev_q, btn_prev_d;
  logic              press_q, press_d;
  logic [3:0]        obst_prev_q, obst_prev_d;
  logic              sens_chg_q, sens_chg_d;
  pwr_state_e        state_q, state_d;
  logic              power_on, bat_low;

  assign raw[CH_F]   = bus.F;
  assign raw[CH_T]   = bus.T;
  assign raw[CH_LE]  = bus.LE;
  assign raw[CH_LD]  = bus.LD;
  assign raw[CH_BAT] = bus.bateria;
  assign raw[CH_BTN] = bus.botao;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk (clk),
      .rst (rst),
      .din (raw[i]),
      .dout(clean[i])
    );
  end

  assign obst_c = clean[CH_LD:CH_F];
  assign bat_ok = clean[CH_BAT];
  assign btn_c  = clean[CH_BTN];

  // Press edge detect and obstacle change detect
  always_comb begin
    btn_prev_d  = btn_c;
    press_d     = btn_c & ~btn_prev_q;
    obst_prev_d = obst_c;
    sens_chg_d  = |(obst_c ^ obst_prev_q);
  end

  // Power FSM next state; battery loss takes priority over a press while ON
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:     if (press_q && bat_ok) state_d = ON;
      ON: begin
        if (!bat_ok)      state_d = BAT_LOW;
        else if (press_q) state_d = OFF;
      end
      BAT_LOW: if (press_q) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  // Power FSM outputs
  always_comb begin
    power_on = (state_q == ON);
    bat_low  = (state_q == BAT_LOW);
  end

  // State register, strobes and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OFF;
      btn_prev_q  <= 1'b0;
      press_q     <= 1'b0;
      obst_prev_q <= '0;
      sens_chg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= btn_prev_d;
      press_q     <= press_d;
      obst_prev_q <= obst_prev_d;
      sens_chg_q  <= sens_chg_d;
    end
  end

`ifdef STUCK_DETECT_EN
  logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;
  logic               fault_q, fault_d;

  // Count cycles an obstacle is held without any change; fault is cleared
  // using the next state so it drops together with leaving ON
  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    if (!power_on || sens_chg_q) begin
      stuck_cnt_d = '0;
    end else if ((|obst_c) && (stuck_cnt_q != STUCK_W'(STUCK_CYCLES))) begin
      stuck_cnt_d = stuck_cnt_q + 1'b1;
    end
    fault_d = (state_d == ON) && (fault_q || (stuck_cnt_d == STUCK_W'(STUCK_CYCLES)));
  end

  // Stuck counter and sticky fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.fault = fault_q;
`else
  // Parameters stay referenced so both builds share one parameter list
  logic [STUCK_W-1:0] stuck_cfg_unused;
  assign stuck_cfg_unused = STUCK_W'(STUCK_CYCLES);
  assign bus.fault        = 1'b0;
`endif

  assign bus.f_c      = clean[CH_F];
  assign bus.t_c      = clean[CH_T];
  assign bus.le_c     = clean[CH_LE];
  assign bus.ld_c     = clean[CH_LD];
  assign bus.bat_ok   = bat_ok;
  assign bus.power_on = power_on;
  assign bus.bat_low  = bat_low;
  assign bus.obst_any = power_on & (|obst_c);
  assign bus.sens_chg = sens_chg_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend with DEB_CYCLES=4, STUCK_CYCLES=20.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Stuck-detection checks are compiled when STUCK_DETECT_EN is defined.
module tb_sensor_frontend;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sensor_frontend_if sif ();

  sensor_frontend #(
    .DEB_CYCLES  (4),
    .CNT_W       (8),
    .STUCK_CYCLES(20),
    .STUCK_W     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, sif.f_c, sif.t_c, sif.le_c, sif.ld_c, sif.bat_ok,
            sif.power_on, sif.bat_low, sif.obst_any, sif.sens_chg, sif.fault};
  endfunction

  task automatic set_all(input logic v);
    sif.F = v; sif.T = v; sif.LE = v; sif.LD = v; sif.bateria = v; sif.botao = v;
  endtask

  // Full press: button held 8 cycles (FSM acts after 8 edges), then released 8 cycles
  task automatic press_release(input string tag, input logic exp_on, input logic exp_low);
    sif.botao = 1'b1;
    tick(8);
    check({tag, "_on"}, 32'(sif.power_on), 32'(exp_on));
    check({tag, "_low"}, 32'(sif.bat_low), 32'(exp_low));
    sif.botao = 1'b0;
    tick(8);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_all(1'b1);
    // Reset with all inputs high
    tick(1);
    check("rst_during", outs(), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_after1", outs(), 32'd0);
    // Reset again mid-debounce with inputs low: no leftover state or strobe
    tick(3);
    rst = 1'b1;
    set_all(1'b0);
    tick(2);
    rst = 1'b0;
    tick(8);
    check("rst_discard", outs(), 32'd0);

    // Front sensor: clean level follows after exactly 6 edges, strobe one cycle later
    sif.F = 1'b1;
    tick(5);
    check("f_lat5", 32'(sif.f_c), 32'd0);
    tick(1);
    check("f_lat6", 32'(sif.f_c), 32'd1);
    check("chg_lat6", 32'(sif.sens_chg), 32'd0);
    tick(1);
    check("chg_lat7", 32'(sif.sens_chg), 32'd1);
    check("obst_off", 32'(sif.obst_any), 32'd0);
    tick(1);
    check("chg_lat8", 32'(sif.sens_chg), 32'd0);
    tick(2);
    sif.F = 1'b0;
    tick(10);
    check("f_fall", 32'(sif.f_c), 32'd0);

    // Bounce shorter than the debounce window is rejected
    for (int i = 0; i < 10; i++) begin
      sif.F = ~sif.F;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        check("bounce_f", 32'(sif.f_c), 32'd0);
        check("bounce_chg", 32'(sif.sens_chg), 32'd0);
      end
    end
    tick(8);
    check("bounce_end", 32'(sif.f_c), 32'd0);

    // Power on / off with good battery
    sif.bateria = 1'b1;
    tick(8);
    check("bat_ok", 32'(sif.bat_ok), 32'd1);
    sif.botao = 1'b1;
    tick(7);
    check("on_lat7", 32'(sif.power_on), 32'd0);
    tick(1);
    check("on_lat8", 32'(sif.power_on), 32'd1);
    sif.botao = 1'b0;
    tick(8);
    check("on_release", 32'(sif.power_on), 32'd1);
    press_release("press_off", 1'b0, 1'b0);
    // Press with low battery stays OFF
    sif.bateria = 1'b0;
    tick(8);
    press_release("press_nobat", 1'b0, 1'b0);

    // ON, obstacle reporting, then battery loss
    sif.bateria = 1'b1;
    tick(8);
    press_release("on_again", 1'b1, 1'b0);
    sif.LD = 1'b1;
    tick(8);
    check("obst_any_on", 32'(sif.obst_any), 32'd1);
`ifndef STUCK_DETECT_EN
    check("fault_tied", 32'(sif.fault), 32'd0);
`endif
    sif.LD = 1'b0;
    tick(8);
    check("obst_any_clr", 32'(sif.obst_any), 32'd0);
    sif.bateria = 1'b0;
    tick(6);
    check("batdrop_lat6", 32'(sif.power_on), 32'd1);
    tick(1);
    check("batdrop_low", 32'(sif.bat_low), 32'd1);
    check("batdrop_on", 32'(sif.power_on), 32'd0);
    tick(1);
    sif.bateria = 1'b1;
    tick(8);
    check("batback_low", 32'(sif.bat_low), 32'd1);
    check("batback_on", 32'(sif.power_on), 32'd0);
    press_release("batlow_off", 1'b0, 1'b0);

    // Press and battery loss reaching the FSM on the same edge: battery wins
    press_release("on_third", 1'b1, 1'b0);
    sif.botao = 1'b1;
    tick(1);
    sif.bateria = 1'b0;
    tick(7);
    check("tie_low", 32'(sif.bat_low), 32'd1);
    check("tie_on", 32'(sif.power_on), 32'd0);
    tick(2);
    check("tie_hold", 32'(sif.bat_low), 32'd1);
    sif.botao = 1'b0;
    sif.bateria = 1'b1;
    tick(8);
    press_release("tie_off", 1'b0, 1'b0);

`ifdef STUCK_DETECT_EN
    // Left sensor held while ON: fault after the stuck limit, cleared on power off
    press_release("stuck_on", 1'b1, 1'b0);
    sif.LE = 1'b1;
    tick(27);
    check("stuck_pre", 32'(sif.fault), 32'd0);
    tick(1);
    check("stuck_set", 32'(sif.fault), 32'd1);
    check("stuck_fsm", 32'(sif.power_on), 32'd1);
    tick(2);
    sif.LE = 1'b0;
    tick(8);
    check("stuck_sticky", 32'(sif.fault), 32'd1);
    sif.botao = 1'b1;
    tick(8);
    check("stuck_off", 32'(sif.power_on), 32'd0);
    check("stuck_clr", 32'(sif.fault), 32'd0);
    sif.botao = 1'b0;
    tick(8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
